// File: rtl/ysyx_23060240_trap_ctrl.sv
// Trap/mret sequencer: drives machine-mode CSR updates over a single read and
// a single write port, then redirects the IFU to the handler or to mepc.
module ysyx_23060240_trap_ctrl #(
  parameter logic [31:0] CAUSE_ECALL   = 32'hb,
  parameter logic [31:0] CAUSE_EBREAK  = 32'h3,
  parameter logic [31:0] CAUSE_ILLEGAL = 32'h2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_valid,
  output logic        trap_ready,
  input  logic        is_ecall,
  input  logic        is_ebreak,
  input  logic        is_illegal,
  input  logic        is_mret,
  input  logic [31:0] trap_pc,
  output logic [11:0] csr_raddr,
  output logic        csr_ren,
  input  logic [31:0] csr_rdata,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        csr_wen,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, W_EPC, W_CAUSE, W_STATUS, RD_VEC, M_STATUS, RD_EPC, REDIR
  } state_e;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  state_e      state_q, state_d;
  logic [31:0] pc_q, cause_q, target_q;
  logic [31:0] cause_sel;
  logic        accept, any_trap;

  assign trap_ready = rst_n && (state_q == IDLE);
  assign accept     = trap_valid && trap_ready;
  assign any_trap   = is_illegal || is_ebreak || is_ecall;
  assign cause_sel  = is_illegal ? CAUSE_ILLEGAL :
                      is_ebreak  ? CAUSE_EBREAK  : CAUSE_ECALL;

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && any_trap)    state_d = W_EPC;
        else if (accept && is_mret) state_d = M_STATUS;
      end
      W_EPC:    state_d = W_CAUSE;
      W_CAUSE:  state_d = W_STATUS;
      W_STATUS: state_d = RD_VEC;
      RD_VEC:   state_d = REDIR;
      M_STATUS: state_d = RD_EPC;
      RD_EPC:   state_d = REDIR;
      REDIR:    if (redirect_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    csr_wen   = 1'b0;
    csr_waddr = '0;
    csr_wdata = '0;
    csr_ren   = 1'b0;
    csr_raddr = '0;
    unique case (state_q)
      W_EPC: begin
        csr_wen   = 1'b1;
        csr_waddr = ADDR_MEPC;
        csr_wdata = pc_q;
      end
      W_CAUSE: begin
        csr_wen   = 1'b1;
        csr_waddr = ADDR_MCAUSE;
        csr_wdata = cause_q;
      end
      W_STATUS: begin
        // Trap entry: stash MIE into MPIE, mask interrupts, record M-mode.
        csr_ren        = 1'b1;
        csr_raddr      = ADDR_MSTATUS;
        csr_wen        = 1'b1;
        csr_waddr      = ADDR_MSTATUS;
        csr_wdata      = csr_rdata;
        csr_wdata[7]   = csr_rdata[3];
        csr_wdata[3]   = 1'b0;
        csr_wdata[12:11] = 2'b11;
      end
      RD_VEC: begin
        csr_ren   = 1'b1;
        csr_raddr = ADDR_MTVEC;
      end
      M_STATUS: begin
        // mret: restore MIE from MPIE and re-arm MPIE.
        csr_ren        = 1'b1;
        csr_raddr      = ADDR_MSTATUS;
        csr_wen        = 1'b1;
        csr_waddr      = ADDR_MSTATUS;
        csr_wdata      = csr_rdata;
        csr_wdata[3]   = csr_rdata[7];
        csr_wdata[7]   = 1'b1;
        csr_wdata[12:11] = 2'b11;
      end
      RD_EPC: begin
        csr_ren   = 1'b1;
        csr_raddr = ADDR_MEPC;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept && any_trap) begin
        pc_q    <= trap_pc;
        cause_q <= cause_sel;
      end
      if (state_q == RD_VEC) target_q <= csr_rdata & 32'hFFFF_FFFC;
      if (state_q == RD_EPC) target_q <= csr_rdata;
    end
  end

  assign redirect_valid = (state_q == REDIR);
  assign redirect_pc    = redirect_valid ? target_q : '0;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_ysyx_23060240_trap_ctrl.sv
// Bench for ysyx_23060240_trap_ctrl: CSR-file environment, per-cycle
// expectation queue built from the request at accept, plus directed cases.
module tb_ysyx_23060240_trap_ctrl;

  localparam logic [31:0] C_ECALL = 32'hb;
  localparam logic [31:0] C_EBRK  = 32'h3;
  localparam logic [31:0] C_ILL   = 32'h2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trap_valid = 1'b0;
  logic        is_ecall = 1'b0, is_ebreak = 1'b0, is_illegal = 1'b0, is_mret = 1'b0;
  logic [31:0] trap_pc = '0;
  logic        redirect_ready = 1'b1;
  logic        trap_ready, csr_ren, csr_wen, redirect_valid, busy;
  logic [11:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wdata, redirect_pc;

  int total = 0;
  int bad = 0;

  ysyx_23060240_trap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .trap_valid(trap_valid), .trap_ready(trap_ready),
    .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_illegal(is_illegal), .is_mret(is_mret),
    .trap_pc(trap_pc), .csr_raddr(csr_raddr), .csr_ren(csr_ren), .csr_rdata(csr_rdata),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // CSR file seen by the DUT; the bench can preload it through set_*.
  logic [31:0] mstatus_r = '0, mtvec_r = '0, mepc_r = '0, mcause_r = '0;
  logic        set_en = 1'b0;
  logic [11:0] set_addr = '0;
  logic [31:0] set_data = '0;

  always @(posedge clk) begin
    logic [11:0] a;
    logic [31:0] d;
    a = set_en ? set_addr : csr_waddr;
    d = set_en ? set_data : csr_wdata;
    if (set_en || (rst_n && csr_wen)) begin
      case (a)
        12'h300: mstatus_r = d;
        12'h305: mtvec_r   = d;
        12'h341: mepc_r    = d;
        12'h342: mcause_r  = d;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (csr_raddr)
      12'h300: csr_rdata = mstatus_r;
      12'h305: csr_rdata = mtvec_r;
      12'h341: csr_rdata = mepc_r;
      12'h342: csr_rdata = mcause_r;
      default: csr_rdata = 32'h0;
    endcase
  end

  // Expected outputs for one cycle of a request's life.
  typedef struct packed {
    logic        busy;
    logic        wen;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        ren;
    logic [11:0] raddr;
    logic        rv;
    logic [31:0] rpc;
  } exp_t;

  exp_t q[$];

  function automatic exp_t mk(input logic wen, input logic [11:0] waddr, input logic [31:0] wdata,
                              input logic ren, input logic [11:0] raddr,
                              input logic rv, input logic [31:0] rpc);
    exp_t e;
    e.busy = 1'b1; e.wen = wen; e.waddr = waddr; e.wdata = wdata;
    e.ren = ren; e.raddr = raddr; e.rv = rv; e.rpc = rpc;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t  e;
    logic  idle;
    logic [31:0] cause, ms;
    if (!rst_n) begin
      q.delete();
      check("rst busy", busy, 0);
      check("rst trap_ready", trap_ready, 0);
      check("rst wen", csr_wen, 0);
      check("rst ren", csr_ren, 0);
      check("rst waddr", csr_waddr, 0);
      check("rst wdata", csr_wdata, 0);
      check("rst raddr", csr_raddr, 0);
      check("rst redirect_valid", redirect_valid, 0);
      check("rst redirect_pc", redirect_pc, 0);
    end else begin
      idle = (q.size() == 0);
      e = idle ? '0 : q[0];
      check("trap_ready", trap_ready, idle);
      check("busy", busy, e.busy);
      check("csr_wen", csr_wen, e.wen);
      check("csr_waddr", csr_waddr, e.waddr);
      check("csr_wdata", csr_wdata, e.wdata);
      check("csr_ren", csr_ren, e.ren);
      check("csr_raddr", csr_raddr, e.raddr);
      check("redirect_valid", redirect_valid, e.rv);
      check("redirect_pc", redirect_pc, e.rpc);
      if (!idle && !(e.rv && !redirect_ready)) void'(q.pop_front());
      if (idle && trap_valid) begin
        ms = mstatus_r;
        if (is_illegal || is_ebreak || is_ecall) begin
          cause = is_illegal ? C_ILL : (is_ebreak ? C_EBRK : C_ECALL);
          q.push_back(mk(1, 12'h341, trap_pc, 0, 0, 0, 0));
          q.push_back(mk(1, 12'h342, cause, 0, 0, 0, 0));
          q.push_back(mk(1, 12'h300, (ms & ~32'h1888) | 32'h1800 | (ms[3] ? 32'h80 : 32'h0),
                         1, 12'h300, 0, 0));
          q.push_back(mk(0, 0, 0, 1, 12'h305, 0, 0));
          q.push_back(mk(0, 0, 0, 0, 0, 1, mtvec_r - (mtvec_r % 4)));
        end else if (is_mret) begin
          q.push_back(mk(1, 12'h300, (ms & ~32'h1888) | 32'h1880 | (ms[7] ? 32'h8 : 32'h0),
                         1, 12'h300, 0, 0));
          q.push_back(mk(0, 0, 0, 1, 12'h341, 0, 0));
          q.push_back(mk(0, 0, 0, 0, 0, 1, mepc_r));
        end
      end
    end
  end

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    set_en = 1'b1; set_addr = a; set_data = d;
    @(posedge clk); #1;
    set_en = 1'b0;
  endtask

  task automatic drive(input logic [3:0] k, input logic [31:0] pc);
    trap_valid = 1'b1;
    {is_illegal, is_ebreak, is_ecall, is_mret} = k;
    trap_pc = pc;
  endtask

  task automatic release_req();
    trap_valid = 1'b0;
    {is_illegal, is_ebreak, is_ecall, is_mret} = 4'b0;
  endtask

  // Issue one request from IDLE; n = cycle offset of the first redirect_valid.
  task automatic issue(input logic [3:0] k, input logic [31:0] pc, output int n);
    @(posedge clk); #1;
    drive(k, pc);
    @(posedge clk); #1;
    release_req();
    n = 1;
    forever begin
      @(negedge clk);
      if (redirect_valid) break;
      n++;
      if (n > 20) begin
        check("redirect timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int c = 0;
    while (q.size() != 0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("idle timeout", q.size(), 0);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset trap_ready low", trap_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset trap_ready", trap_ready, 1);
    check("post-reset busy", busy, 0);

    // ecall entry
    poke(12'h300, 32'h0000_0008);
    poke(12'h305, 32'h8000_0101);
    issue(4'b0010, 32'h8000_0010, n);
    check("ecall latency", n, 5);
    check("ecall redirect_pc", redirect_pc, 32'h8000_0100);
    wait_idle();
    check("ecall mepc", mepc_r, 32'h8000_0010);
    check("ecall mcause", mcause_r, 32'hb);
    check("ecall mstatus", mstatus_r, 32'h0000_1880);

    // mret return
    poke(12'h341, 32'h8000_0014);
    issue(4'b0001, 32'h0, n);
    check("mret latency", n, 3);
    check("mret redirect_pc", redirect_pc, 32'h8000_0014);
    wait_idle();
    check("mret mstatus", mstatus_r, 32'h0000_1888);

    // illegal wins over ecall
    issue(4'b1010, 32'h8000_0020, n);
    check("illegal latency", n, 5);
    wait_idle();
    check("illegal mcause", mcause_r, 32'h2);
    check("illegal mstatus", mstatus_r, 32'h0000_1880);

    // ebreak with a stalled redirect, then a request queued behind it
    poke(12'h305, 32'h8000_0203);
    redirect_ready = 1'b0;
    issue(4'b0100, 32'h8000_0030, n);
    check("ebreak latency", n, 5);
    @(posedge clk); #1;
    drive(4'b0010, 32'h8000_0040);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall redirect_valid", redirect_valid, 1);
      check("stall redirect_pc", redirect_pc, 32'h8000_0200);
      check("stall trap_ready", trap_ready, 0);
      check("stall csr_wen", csr_wen, 0);
    end
    check("ebreak mcause", mcause_r, 32'h3);
    @(posedge clk); #1;
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("return idle accepts", trap_ready, 1);
    @(posedge clk); #1;
    release_req();
    wait_idle();
    check("queued mepc", mepc_r, 32'h8000_0040);
    check("queued mcause", mcause_r, 32'hb);

    // request with no kind flag is dropped
    @(posedge clk); #1;
    drive(4'b0000, 32'h8000_0050);
    repeat (3) begin
      @(negedge clk);
      check("noflag busy", busy, 0);
      check("noflag trap_ready", trap_ready, 1);
      check("noflag csr_wen", csr_wen, 0);
    end
    @(posedge clk); #1;
    release_req();

    // reset during W_CAUSE
    poke(12'h342, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    drive(4'b0010, 32'h8000_0060);
    @(posedge clk); #1;
    release_req();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst wen", csr_wen, 0);
    check("midrst busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("after rst busy", busy, 0);
    check("after rst trap_ready", trap_ready, 1);
    check("midrst mcause kept", mcause_r, 32'hDEAD_BEEF);
    check("midrst mepc written", mepc_r, 32'h8000_0060);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060240_trap_ctrl.md
YSYX_23060240_TRAP_CTRL -- requirements
Module: ysyx_23060240_trap_ctrl

Interface
REQ-001 SHALL have parameter CAUSE_ECALL, default 32'hb, mcause value for ecall from M-mode.
REQ-002 SHALL have parameter CAUSE_EBREAK, default 32'h3, mcause value for ebreak.
REQ-003 SHALL have parameter CAUSE_ILLEGAL, default 32'h2, mcause value for illegal instruction.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port trap_valid  input  1  EXU presents a trap or mret request.
REQ-007 SHALL have port trap_ready  output  1  request accepted when trap_valid && trap_ready.
REQ-008 SHALL have ports is_ecall, is_ebreak, is_illegal, is_mret  input  1 each  request kind; sampled at accept.
REQ-009 SHALL have port trap_pc  input  32  PC of the trapping instruction; sampled at accept.
REQ-010 SHALL have ports csr_raddr  output  12, csr_ren  output  1, csr_rdata  input  32  CSR read port; rdata is combinational from raddr in the same cycle.
REQ-011 SHALL have ports csr_waddr  output  12, csr_wdata  output  32, csr_wen  output  1  single CSR write port, committed at the clock edge.
REQ-012 SHALL have ports redirect_valid  output  1, redirect_pc  output  32, redirect_ready  input  1  PC redirect handshake to IFU.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE; stalls the pipeline.

Function
REQ-014 SHALL implement FSM states IDLE, W_EPC, W_CAUSE, W_STATUS, RD_VEC, M_STATUS, RD_EPC, REDIR.
REQ-015 trap_ready SHALL equal (state==IDLE); requests are never accepted in other states.
REQ-016 At accept, kind priority SHALL be illegal > ebreak > ecall > mret; the cause and PC SHALL be latched internally.
REQ-017 An accepted request with no kind flag set SHALL be dropped; the FSM stays in IDLE and writes no CSR.
REQ-018 Trap path (illegal/ebreak/ecall): IDLE -> W_EPC -> W_CAUSE -> W_STATUS -> RD_VEC -> REDIR, one cycle per state except REDIR.
REQ-019 W_EPC SHALL write mepc (12'h341) with the latched PC.
REQ-020 W_CAUSE SHALL write mcause (12'h342) with the latched cause.
REQ-021 W_STATUS SHALL read mstatus (12'h300) and write it back with MPIE(bit7)=old MIE(bit3), MIE=0, MPP(bits12:11)=2'b11, other bits unchanged.
REQ-022 RD_VEC SHALL read mtvec (12'h305) and latch target = rdata & 32'hFFFF_FFFC.
REQ-023 mret path: IDLE -> M_STATUS -> RD_EPC -> REDIR.
REQ-024 M_STATUS SHALL write mstatus with MIE=old MPIE, MPIE=1, MPP=2'b11, other bits unchanged.
REQ-025 RD_EPC SHALL read mepc and latch target = rdata.
REQ-026 In REDIR, redirect_valid SHALL be 1 and redirect_pc SHALL hold the latched target, stable until redirect_ready; on redirect_valid && redirect_ready the FSM returns to IDLE next cycle.
REQ-027 csr_wen SHALL be high only in W_EPC, W_CAUSE, W_STATUS and M_STATUS; csr_ren only in W_STATUS, RD_VEC, M_STATUS and RD_EPC.
REQ-028 When csr_wen/csr_ren are low, csr_waddr, csr_wdata and csr_raddr SHALL be 0.
REQ-029 Latency: trap accepted at edge T SHALL produce redirect_valid from cycle T+5; mret from cycle T+3.
REQ-030 redirect_ready held low SHALL stall in REDIR indefinitely, with no further CSR access.
REQ-031 A trap_valid arriving in the cycle the FSM returns to IDLE SHALL be accepted only in the following IDLE cycle, never merged with the completing request.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, clear latched PC/cause/target, and drive busy=0, trap_ready=1 (once rst_n high), redirect_valid=0, redirect_pc=0, csr_wen=0, csr_ren=0 and all addresses and data 0.
REQ-033 Reset mid-sequence SHALL abandon the sequence; no further CSR write occurs after rst_n falls.

Verification
REQ-034 ecall, trap_pc=32'h8000_0010, mstatus=32'h0000_0008, mtvec=32'h8000_0101 -> writes mepc=32'h8000_0010, mcause=32'hb, mstatus=32'h0000_1880; redirect_pc=32'h8000_0100 at T+5.
REQ-035 mret with mstatus=32'h0000_1880, mepc=32'h8000_0014 -> mstatus written 32'h0000_1888; redirect_pc=32'h8000_0014 at T+3.
REQ-036 is_illegal=1 and is_ecall=1 together -> mcause written 32'h2.
REQ-037 redirect_ready low for 4 cycles in REDIR -> redirect_valid high and redirect_pc constant for 4 cycles; a new trap_valid is not accepted.
REQ-038 rst_n pulsed low during W_CAUSE -> no mcause write; all outputs 0 during reset; busy=0 and trap_ready=1 next cycle after release.
REQ-039 trap_valid=1 with no kind flag -> trap_ready=1, busy stays 0, no CSR access.
